if_prefetch_stage: RTL and testbench

Instruction-fetch front end of the five-stage pipeline. It sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues single-outstanding requests to a variable-latency instruction memory. Fetched {PC, instruction} pairs are buffered in a small FIFO and presented to IF/ID. The block honours the pipeline `stall` and redirects on `Branch` (from EXE) or `Jump` (from ID), flushing all wrong-path state.

---
 rtl/if_prefetch_stage.sv | 168 ++++++++++++++++
 tb/tb_if_prefetch_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch prefetch stage: owns the fetch PC and issues one request
// at a time to a variable-latency instruction memory. Returned {pc, inst}
// pairs are buffered in a small FIFO that feeds the IF/ID register.
// A Branch (EXE) or Jump (ID) redirect flushes the FIFO. It also turns any
// in-flight response into a discard.
module if_prefetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        stall,
    input  logic        Branch,
    input  logic [31:0] EXE_bpc,
    input  logic        Jump,
    input  logic [31:0] ID_jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_Inst,
    output logic [31:0] IF_PC,
    output logic        IF_Valid
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } fetch_state_e;

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      pc_mem_q   [DEPTH];
    logic [31:0]      inst_mem_q [DEPTH];

    logic        redir_s;
    logic [31:0] target_s;
    logic        space_s;
    logic        req_s;
    logic        push_s;
    logic        valid_s;
    logic        pop_s;

    // Request, push/pop and redirect decode. Branch beats Jump because it
    // belongs to the older instruction. The space check deliberately uses
    // the pre-pop count so a full FIFO can never be overrun.
    always_comb begin
        redir_s  = Branch | Jump;
        target_s = Branch ? EXE_bpc : ID_jpc;
        space_s  = (count_q < CNT_W'(DEPTH));
        req_s    = (state_q == S_IDLE) && !redir_s && space_s;
        push_s   = (state_q == S_WAIT) && imem_ack && !redir_s;
        valid_s  = (count_q != {CNT_W{1'b0}}) && !redir_s;
        pop_s    = valid_s && !stall;
    end

    // Next-state logic for the fetch FSM, fetch PC and FIFO bookkeeping.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        case (state_q)
            S_IDLE: begin
                if (req_s) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    state_d = S_IDLE;
                end else if (redir_s) begin
                    state_d = S_DISCARD;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DISCARD: begin
                if (imem_ack) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DISCARD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (redir_s) begin
            fetch_pc_d = target_s;
            count_d    = {CNT_W{1'b0}};
            rd_ptr_d   = {PTR_W{1'b0}};
            wr_ptr_d   = {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            end else begin
                fetch_pc_d = fetch_pc_q;
                wr_ptr_d   = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s && !pop_s) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push_s && pop_s) begin
                count_d = count_q - CNT_W'(1);
            end else begin
                count_d = count_q;
            end
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            count_q    <= {CNT_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // FIFO payload storage; contents are qualified by count, so no reset.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
            inst_mem_q[wr_ptr_q] <= imem_rdata;
        end
    end

    // Outputs: requests are masked during reset; invalid head reads as a nop.
    always_comb begin
        imem_req  = req_s && !Reset;
        imem_addr = {fetch_pc_q[31:2], 2'b00};
        IF_Valid  = valid_s;
        if (valid_s) begin
            IF_PC   = pc_mem_q[rd_ptr_q];
            IF_Inst = inst_mem_q[rd_ptr_q];
        end else begin
            IF_PC   = 32'h0000_0000;
            IF_Inst = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: a behavioural memory with 1..3 cycle latency,
// a path-based reference (each redirect/reset starts a new in-order PC stream)
// and a scoreboard queue checked by an independent monitor process.
module tb_if_prefetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int unsigned DEPTH  = 4;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        stall = 1'b0;
    logic        Branch = 1'b0;
    logic [31:0] EXE_bpc = 32'h0;
    logic        Jump = 1'b0;
    logic [31:0] ID_jpc = 32'h0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] IF_Inst;
    logic [31:0] IF_PC;
    logic        IF_Valid;

    if_prefetch_stage #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .Reset(Reset), .stall(stall),
        .Branch(Branch), .EXE_bpc(EXE_bpc), .Jump(Jump), .ID_jpc(ID_jpc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .IF_Inst(IF_Inst), .IF_PC(IF_PC), .IF_Valid(IF_Valid)
    );

    always #10 CLK = ~CLK;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          lat_mode = 1;
    bit          mem_busy = 1'b0;
    int          mem_due = 0;
    logic [31:0] mem_addr = 32'h0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_req_pc = 32'h0;
    int          pops = 0;
    logic [31:0] last_pop_pc = 32'h0;
    logic        req_s, valid_s;
    logic [31:0] addr_s, pc_s, inst_s;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h5A5A};
    endfunction

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // A new fetch path: expected deliveries and requests are t, t+4, t+8, ...
    task automatic new_path(input logic [31:0] t);
        logic [31:0] p;
        exp_q.delete();
        for (int k = 0; k < 128; k++) begin
            p = t + 32'(4 * k);
            exp_q.push_back({p, rom(p)});
        end
        exp_req_pc = t;
    endtask

    // One clock cycle: drive inputs, play the memory, sample outputs.
    task automatic step(input logic rst, input logic st, input logic br, input logic [31:0] bpc,
                        input logic jp, input logic [31:0] jpc);
        logic was_rst;
        @(negedge CLK);
        cyc++;
        was_rst = Reset;
        Reset = rst; stall = st; Branch = br; EXE_bpc = bpc; Jump = jp; ID_jpc = jpc;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        if (rst) begin
            mem_busy = 1'b0;
        end else if (mem_busy && cyc == mem_due) begin
            imem_ack = 1'b1; imem_rdata = rom(mem_addr); mem_busy = 1'b0;
        end
        if (!rst && was_rst) new_path(RST_PC);
        else if (!rst && (br || jp)) new_path(br ? bpc : jpc);
        #1;
        req_s = imem_req; addr_s = imem_addr; valid_s = IF_Valid; pc_s = IF_PC; inst_s = IF_Inst;
        if (req_s) begin
            check_eq("req_addr", addr_s, exp_req_pc);
            check_eq("one_outstanding", 32'(mem_busy), 32'd0);
            exp_req_pc = exp_req_pc + 32'd4;
            mem_busy = 1'b1;
            mem_due  = cyc + ((lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode);
            mem_addr = addr_s;
        end
    endtask

    task automatic idle(input logic st);
        step(1'b0, st, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic wait_req(input string name, input logic st);
        bit seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            idle(st);
            if (req_s) begin seen = 1'b1; break; end
        end
        if (!seen) check_eq(name, 32'd0, 32'd1);
    endtask

    task automatic wait_pops(input string name, input int n);
        int start = pops;
        for (int i = 0; i < 60 && pops < start + n; i++) begin
            idle(1'b0);
            #2;
        end
        if (pops < start + n) check_eq(name, 32'(pops - start), 32'(n));
    endtask

    // Monitor: compares the presented head against the scoreboard, pops on consume.
    initial begin : monitor
        logic [63:0] e;
        forever begin
            @(negedge CLK);
            #2;
            if (Reset) begin
                check_eq("rst_valid", 32'(IF_Valid), 32'd0);
                check_eq("rst_req", 32'(imem_req), 32'd0);
            end else if (Branch || Jump) begin
                check_eq("redir_valid", 32'(IF_Valid), 32'd0);
            end else if (IF_Valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_underflow", IF_PC, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q[0];
                    check_eq("head_pc", IF_PC, e[63:32]);
                    check_eq("head_inst", IF_Inst, e[31:0]);
                    if (!stall) begin
                        void'(exp_q.pop_front());
                        pops++;
                        last_pop_pc = IF_PC;
                    end
                end
            end else begin
                check_eq("nop_pc", IF_PC, 32'h0);
                check_eq("nop_inst", IF_Inst, 32'h0);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [31:0] t;
        int r;
        bit found;
        logic st, br, jp;

        // Reset state and first-request latency with a 1-cycle memory.
        lat_mode = 1;
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("reset_req", 32'(req_s), 32'd0);
        check_eq("reset_valid", 32'(valid_s), 32'd0);
        check_eq("reset_pc", pc_s, 32'h0);
        check_eq("reset_inst", inst_s, 32'h0);
        idle(1'b0);
        check_eq("first_req", 32'(req_s), 32'd1);
        check_eq("first_addr", addr_s, RST_PC);
        idle(1'b0);
        check_eq("lat_n1_valid", 32'(valid_s), 32'd0);
        idle(1'b0);
        check_eq("lat_n2_valid", 32'(valid_s), 32'd1);
        check_eq("lat_n2_pc", pc_s, RST_PC);
        idle(1'b0);
        check_eq("one_cycle_valid", 32'(valid_s), 32'd0);
        idle(1'b0);
        check_eq("second_valid", 32'(valid_s), 32'd1);
        check_eq("second_pc", pc_s, 32'h4);
        repeat (6) idle(1'b0);

        // Stall fills the FIFO, then it drains on consecutive cycles.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (10) idle(1'b1);
        check_eq("full_no_req", 32'(req_s), 32'd0);
        check_eq("stall_head_pc", pc_s, 32'h0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            check_eq("drain_consec", 32'(valid_s), 32'd1);
            check_eq("drain_pc", pc_s, 32'(4 * i));
        end
        repeat (4) idle(1'b0);

        // Branch while a 3-cycle request to 8 is pending.
        lat_mode = 3;
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            idle(1'b0);
            if (req_s && addr_s == 32'h8) begin found = 1'b1; break; end
        end
        check_eq("saw_req8", 32'(found), 32'd1);
        step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        check_eq("branch_valid", 32'(valid_s), 32'd0);
        wait_req("branch_req_timeout", 1'b0);
        check_eq("branch_target_req", addr_s, 32'h40);
        wait_pops("branch_pop_timeout", 1);
        check_eq("branch_first_pc", last_pop_pc, 32'h40);

        // Branch and Jump together: Branch wins.
        lat_mode = 1;
        repeat (3) idle(1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h100);
        check_eq("bj_valid", 32'(valid_s), 32'd0);
        wait_req("bj_req_timeout", 1'b0);
        check_eq("bj_target", addr_s, 32'h80);

        // Redirect in the same cycle as the ack: data dropped, next cycle requests target.
        wait_req("ack_redir_req_timeout", 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200);
        check_eq("ack_redir_was_ack", 32'(imem_ack), 32'd1);
        idle(1'b0);
        check_eq("ack_redir_req", 32'(req_s), 32'd1);
        check_eq("ack_redir_addr", addr_s, 32'h200);
        wait_pops("ack_redir_pop_timeout", 1);
        check_eq("ack_redir_first_pc", last_pop_pc, 32'h200);

        // Wrap of the fetch PC past 2^32.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        wait_pops("wrap_pop_timeout", 1);
        check_eq("wrap_pc0", last_pop_pc, 32'hFFFF_FFFC);
        wait_pops("wrap_pop_timeout", 1);
        check_eq("wrap_pc1", last_pop_pc, 32'h0000_0000);

        // Asynchronous reset in the middle of a request with a non-empty FIFO.
        lat_mode = 3;
        repeat (8) idle(1'b1);
        wait_req("mid_req_timeout", 1'b1);
        idle(1'b1);
        check_eq("pre_reset_valid", 32'(valid_s), 32'd1);
        #5;
        Reset = 1'b1;
        mem_busy = 1'b0;
        #2;
        check_eq("async_req", 32'(imem_req), 32'd0);
        check_eq("async_valid", 32'(IF_Valid), 32'd0);
        check_eq("async_pc", IF_PC, 32'h0);
        check_eq("async_inst", IF_Inst, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(1'b0);
        check_eq("restart_req", 32'(req_s), 32'd1);
        check_eq("restart_addr", addr_s, RST_PC);

        // Randomised traffic: random latency, stalls and redirects.
        lat_mode = 0;
        pops = 0;
        for (int i = 0; i < 1500; i++) begin
            st = ($urandom_range(0, 3) == 0);
            r  = int'($urandom_range(0, 99));
            br = (r < 3);
            jp = (r >= 2 && r < 5);
            t  = 32'($urandom_range(0, 1023)) << 2;
            if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF0;
            step(1'b0, st, br, t, jp, t + 32'h1000);
        end
        repeat (30) idle(1'b0);
        #2;
        check_eq("progress", 32'(pops >= 100), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
